// File: rtl/wb_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_bus_pkg
// Purpose  : Shared widths, bus state encoding and defaults for wb_shared_bus.
// Revision : 1.0 - initial release
// ============================================================================
package wb_bus_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    localparam int WB_TIMEOUT_CYCLES_DEF = 255;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bus_state_t;

endpackage : wb_bus_pkg
`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_rr_arbiter
// Purpose  : Combinational round-robin pick: first requester after i_last.
// Revision : 1.0 - initial release
// ============================================================================
module wb_rr_arbiter
    import wb_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_last,
    output logic [NUM_MASTERS-1:0] o_gnt_oh,
    output logic [IDX_W-1:0]       o_gnt_idx
);

    localparam logic [NUM_MASTERS-1:0] c_ONE = NUM_MASTERS'(1);

    logic                   w_found;
    int                     w_cand;
    logic [NUM_MASTERS-1:0] w_req_rot;

    // Offsets 1..N from the last winner give strict rotating priority.
    always_comb begin
        o_gnt_oh  = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_cand    = 0;
        w_req_rot = '0;
        for (int off = 1; off <= NUM_MASTERS; off++) begin
            w_cand    = (int'(i_last) + off) % NUM_MASTERS;
            w_req_rot = i_req >> w_cand;
            if (!w_found && w_req_rot[0]) begin
                w_found   = 1'b1;
                o_gnt_oh  = c_ONE << w_cand;
                o_gnt_idx = IDX_W'(w_cand);
            end
        end
    end

endmodule : wb_rr_arbiter
`default_nettype wire

// File: rtl/wb_shared_bus.sv
`default_nettype none
// ============================================================================
// Module   : wb_shared_bus
// Purpose  : Round-robin Wishbone shared bus, cyc-locked tenures, nibble decode.
//            Define WB_BUS_TIMEOUT_EN to enable the bus-timeout watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module wb_shared_bus
    import wb_bus_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int NUM_SLAVES     = 4,
    parameter int SEL_MSB        = 31,
    parameter int SEL_LSB        = 28,
    parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES_DEF
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_MASTERS-1:0]          m_cyc_i,
    input  logic [NUM_MASTERS-1:0]          m_stb_i,
    input  logic [NUM_MASTERS-1:0]          m_we_i,
    input  logic [WB_SEL_W*NUM_MASTERS-1:0] m_sel_i,
    input  logic [WB_ADR_W*NUM_MASTERS-1:0] m_adr_i,
    input  logic [WB_DAT_W*NUM_MASTERS-1:0] m_dat_i,
    output logic [WB_DAT_W*NUM_MASTERS-1:0] m_dat_o,
    output logic [NUM_MASTERS-1:0]          m_ack_o,
    output logic [NUM_MASTERS-1:0]          m_err_o,
    output logic [NUM_SLAVES-1:0]           s_cyc_o,
    output logic [NUM_SLAVES-1:0]           s_stb_o,
    output logic [WB_ADR_W-1:0]             s_adr_o,
    output logic [WB_DAT_W-1:0]             s_dat_o,
    output logic [WB_SEL_W-1:0]             s_sel_o,
    output logic                            s_we_o,
    input  logic [WB_DAT_W*NUM_SLAVES-1:0]  s_dat_i,
    input  logic [NUM_SLAVES-1:0]           s_ack_i,
    input  logic [NUM_SLAVES-1:0]           s_err_i
);

    localparam int c_MIDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int c_SEL_W  = SEL_MSB - SEL_LSB + 1;
    localparam int c_M_PAD  = 1 << c_MIDX_W;
    localparam int c_S_PAD  = 1 << c_SEL_W;

    bus_state_t            r_state, w_state_nxt;
    logic [c_MIDX_W-1:0]   r_gnt, w_gnt_nxt;
    logic [c_MIDX_W-1:0]   r_last, w_last_nxt;
    logic [c_MIDX_W-1:0]   w_arb_idx;
    logic [NUM_MASTERS-1:0] w_arb_oh;

    // Power-of-two padded views so the grant/select indices never run off the end.
    logic [WB_ADR_W-1:0] w_m_adr [c_M_PAD];
    logic [WB_DAT_W-1:0] w_m_dat [c_M_PAD];
    logic [WB_SEL_W-1:0] w_m_sel [c_M_PAD];
    logic                w_m_cyc [c_M_PAD];
    logic                w_m_stb [c_M_PAD];
    logic                w_m_we  [c_M_PAD];
    logic [WB_DAT_W-1:0] w_s_dat [c_S_PAD];
    logic                w_s_ack [c_S_PAD];
    logic                w_s_err [c_S_PAD];
    logic                w_s_map [c_S_PAD];

    logic                w_busy, w_cyc, w_stb, w_hit, w_ack, w_err, w_timeout;
    logic [WB_ADR_W-1:0] w_adr;
    logic [c_SEL_W-1:0]  w_sidx;
    logic [WB_DAT_W-1:0] w_rdata;

    generate
        for (genvar k = 0; k < c_M_PAD; k++) begin : g_m_view
            if (k < NUM_MASTERS) begin : g_used
                assign w_m_adr[k] = m_adr_i[k*WB_ADR_W +: WB_ADR_W];
                assign w_m_dat[k] = m_dat_i[k*WB_DAT_W +: WB_DAT_W];
                assign w_m_sel[k] = m_sel_i[k*WB_SEL_W +: WB_SEL_W];
                assign w_m_cyc[k] = m_cyc_i[k];
                assign w_m_stb[k] = m_stb_i[k];
                assign w_m_we[k]  = m_we_i[k];
            end else begin : g_pad
                assign w_m_adr[k] = '0;
                assign w_m_dat[k] = '0;
                assign w_m_sel[k] = '0;
                assign w_m_cyc[k] = 1'b0;
                assign w_m_stb[k] = 1'b0;
                assign w_m_we[k]  = 1'b0;
            end
        end

        for (genvar i = 0; i < c_S_PAD; i++) begin : g_s_view
            if (i < NUM_SLAVES) begin : g_used
                assign w_s_dat[i] = s_dat_i[i*WB_DAT_W +: WB_DAT_W];
                assign w_s_ack[i] = s_ack_i[i];
                assign w_s_err[i] = s_err_i[i];
                assign w_s_map[i] = 1'b1;
            end else begin : g_pad
                assign w_s_dat[i] = '0;
                assign w_s_ack[i] = 1'b0;
                assign w_s_err[i] = 1'b0;
                assign w_s_map[i] = 1'b0;
            end
        end
    endgenerate

    wb_rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (c_MIDX_W)
    ) u_arb (
        .i_req     (m_cyc_i),
        .i_last    (r_last),
        .o_gnt_oh  (w_arb_oh),
        .o_gnt_idx (w_arb_idx)
    );

    assign w_busy  = (r_state == BUSY);
    assign w_adr   = w_m_adr[r_gnt];
    assign w_cyc   = w_m_cyc[r_gnt];
    assign w_stb   = w_m_stb[r_gnt];
    assign w_sidx  = w_adr[SEL_MSB:SEL_LSB];
    assign w_hit   = w_busy & w_s_map[w_sidx];
    assign w_rdata = w_hit ? w_s_dat[w_sidx] : '0;

    // A watchdog expiry overrides the slave: the cycle becomes an error, never an ack.
    assign w_ack = w_hit & w_stb & w_s_ack[w_sidx] & ~w_timeout;
    assign w_err = (w_busy & w_stb & (w_hit ? w_s_err[w_sidx] : 1'b1)) | w_timeout;

    assign s_adr_o = w_busy ? w_adr : '0;
    assign s_dat_o = w_busy ? w_m_dat[r_gnt] : '0;
    assign s_sel_o = w_busy ? w_m_sel[r_gnt] : '0;
    assign s_we_o  = w_busy & w_m_we[r_gnt];

    generate
        for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_s_out
            assign s_cyc_o[i] = w_hit & (w_sidx == c_SEL_W'(i)) & w_cyc;
            assign s_stb_o[i] = w_hit & (w_sidx == c_SEL_W'(i)) & w_stb & ~w_timeout;
        end
        for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_m_out
            assign m_ack_o[k] = (r_gnt == c_MIDX_W'(k)) & w_ack;
            assign m_err_o[k] = (r_gnt == c_MIDX_W'(k)) & w_err;
            assign m_dat_o[k*WB_DAT_W +: WB_DAT_W] = w_rdata;
        end
    endgenerate

`ifdef WB_BUS_TIMEOUT_EN
    localparam logic [15:0] c_WDOG_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] r_wdog;

    assign w_timeout = w_busy & w_stb & (r_wdog == c_WDOG_LIMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i || !w_busy || !w_stb || w_ack || w_err) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 16'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (|w_arb_oh) begin
                    w_gnt_nxt   = w_arb_idx;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                // Tenure lasts exactly as long as the owner holds cyc.
                if (!w_cyc) begin
                    w_last_nxt  = r_gnt;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_last  <= c_MIDX_W'(NUM_MASTERS - 1);
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

endmodule : wb_shared_bus
`default_nettype wire
